// File: rtl/maze_path_checker.sv
// Replays a 2-bit move stream from (0,0) over a locally held 16x16 maze bitmap
// and reports pass/fail, an error code, the legal step count and the final position.
module maze_path_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       map_we,
  input  logic [3:0] map_x,
  input  logic [3:0] map_y,
  input  logic       map_din,
  input  logic [1:0] move,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic       path_end,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [1:0] err_code,
  output logic [8:0] step_count,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic [2:0] dbg_state
);

  // Handshake: a move transfers on a rising edge where move_valid and move_ready
  // are both 1; move_ready is a flop driven only from state, never from move_valid.
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, PASS, FAIL} state_t;

  state_t       state;
  logic [255:0] maze;
  logic         map_open;
  logic         oob;
  logic [3:0]   nx;
  logic [3:0]   ny;

  assign dbg_state = state;
  assign map_open  = (state == IDLE) || (state == PASS) || (state == FAIL);

  // Bounds are checked before the 4-bit add so a wrapped coordinate is never used.
  always_comb begin
    oob = 1'b0;
    nx  = cur_x;
    ny  = cur_y;
    case (move)
      2'b00: begin oob = (cur_y == 4'd0);  ny = cur_y - 4'd1; end
      2'b01: begin oob = (cur_x == 4'd15); nx = cur_x + 4'd1; end
      2'b10: begin oob = (cur_x == 4'd0);  nx = cur_x - 4'd1; end
      default: begin oob = (cur_y == 4'd15); ny = cur_y + 4'd1; end
    endcase
  end

  // The bitmap survives reset; writes are locked out while a check runs.
  always_ff @(posedge clk) begin
    if (!rst && map_we && map_open) maze[{map_y, map_x}] <= map_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      move_ready <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      err_code   <= 2'b00;
      step_count <= 9'd0;
      cur_x      <= 4'd0;
      cur_y      <= 4'd0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            cur_x      <= 4'd0;
            cur_y      <= 4'd0;
            step_count <= 9'd0;
            pass       <= 1'b0;
            if (maze[8'd0]) begin
              state      <= FAIL;
              fail       <= 1'b1;
              err_code   <= 2'b11;
              busy       <= 1'b0;
              move_ready <= 1'b0;
            end else begin
              state      <= WAIT;
              fail       <= 1'b0;
              err_code   <= 2'b00;
              busy       <= 1'b1;
              move_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (move_valid) begin
            move_ready <= 1'b0;
            if (oob) begin
              state    <= FAIL;
              fail     <= 1'b1;
              err_code <= 2'b01;
              busy     <= 1'b0;
            end else begin
              state <= CHECK;
              cur_x <= nx;
              cur_y <= ny;
            end
          end else if (path_end) begin
            state      <= FAIL;
            fail       <= 1'b1;
            err_code   <= 2'b11;
            busy       <= 1'b0;
            move_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (maze[{cur_y, cur_x}]) begin
            state    <= FAIL;
            fail     <= 1'b1;
            err_code <= 2'b10;
            busy     <= 1'b0;
          end else begin
            if (step_count != 9'h1FF) step_count <= step_count + 9'd1;
            if ((cur_x == 4'd15) && (cur_y == 4'd15)) begin
              state <= PASS;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= WAIT;
              move_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_checker.sv
// Randomised and directed bench for maze_path_checker with a path-walking
// reference model and a verdict scoreboard.
module tb_maze_path_checker;

  logic       clk = 1'b0;
  logic       rst, start, map_we, map_din, move_valid, path_end;
  logic [3:0] map_x, map_y;
  logic [1:0] move;
  logic       move_ready, busy, pass, fail;
  logic [1:0] err_code;
  logic [8:0] step_count;
  logic [3:0] cur_x, cur_y;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  bit         ref_maze [16][16];   // [y][x], 1 = wall
  logic [1:0] path_q[$];
  // verdict packing: {pass, fail, err[1:0], step[8:0], x[3:0], y[3:0]}
  logic [20:0] exp_q[$];
  logic        start_q = 1'b0;
  logic        busy_q  = 1'b0;

  maze_path_checker dut (
    .clk(clk), .rst(rst), .start(start), .map_we(map_we), .map_x(map_x),
    .map_y(map_y), .map_din(map_din), .move(move), .move_valid(move_valid),
    .move_ready(move_ready), .path_end(path_end), .busy(busy), .pass(pass),
    .fail(fail), .err_code(err_code), .step_count(step_count), .cur_x(cur_x),
    .cur_y(cur_y), .dbg_state(dbg_state)
  );

  // clock / reset-independent edge capture
  always #5 clk = ~clk;

  always @(posedge clk) begin
    start_q <= start;
    busy_q  <= busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [20:0] pack_v(input bit p, input bit f, input int e,
                                         input int s, input int x, input int y);
    logic [1:0] e2; logic [8:0] s9; logic [3:0] x4, y4;
    e2 = e[1:0]; s9 = s[8:0]; x4 = x[3:0]; y4 = y[3:0];
    return {p, f, e2, s9, x4, y4};
  endfunction

  // Walks the path on integer coordinates; any verdict ends the walk.
  function automatic logic [20:0] ref_verdict();
    int x = 0, y = 0, steps = 0, nx, ny;
    if (ref_maze[0][0]) return pack_v(0, 1, 3, 0, 0, 0);
    foreach (path_q[i]) begin
      nx = x; ny = y;
      case (path_q[i])
        2'd0: ny = y - 1;
        2'd1: nx = x + 1;
        2'd2: nx = x - 1;
        default: ny = y + 1;
      endcase
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) return pack_v(0, 1, 1, steps, x, y);
      x = nx; y = ny;
      if (ref_maze[y][x]) return pack_v(0, 1, 2, steps, x, y);
      steps++;
      if (x == 15 && y == 15) return pack_v(1, 0, 0, steps, x, y);
    end
    return pack_v(0, 1, 3, steps, x, y);
  endfunction

  // monitor: a verdict is presented when pass/fail is high after a busy cycle or a start edge
  always @(negedge clk) begin
    logic [20:0] e;
    if ((pass || fail) && (start_q || busy_q) && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pass", pass, e[20]);
        chk("fail", fail, e[19]);
        chk("err_code", err_code, e[18:17]);
        chk("step_count", step_count, e[16:8]);
        chk("cur_x", cur_x, e[7:4]);
        chk("cur_y", cur_y, e[3:0]);
      end
    end
  end

  task automatic write_cell(input int x, input int y, input bit d);
    map_we = 1'b1; map_x = x[3:0]; map_y = y[3:0]; map_din = d;
    ref_maze[y][x] = d;
    @(negedge clk);
    map_we = 1'b0;
  endtask

  task automatic load_maze(input int density);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        write_cell(x, y, ($urandom_range(0, 99) < density));
  endtask

  task automatic add_moves(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) path_q.push_back(m);
  endtask

  // Drives path_q after a start pulse; path_end follows exhaustion or is held throughout.
  task automatic run_check(input bit end_always, input bit mid_write, output int cyc);
    int idx = 0;
    exp_q.push_back(ref_verdict());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    chk("start_to_ready", move_ready, !ref_maze[0][0]);
    while (!(pass || fail) && cyc < 3000) begin
      if (idx < path_q.size()) begin
        move_valid = 1'b1; move = path_q[idx]; path_end = end_always;
      end else begin
        move_valid = 1'b0; path_end = 1'b1;
      end
      if (mid_write && cyc == 0) begin
        map_we = 1'b1; map_x = 4'd1; map_y = 4'd0; map_din = 1'b1;
      end else begin
        map_we = 1'b0;
      end
      if (move_valid && move_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    move_valid = 1'b0; path_end = 1'b0; map_we = 1'b0;
    if (cyc >= 3000) chk("verdict_timeout", 1, 0);
    chk("ready_after_verdict", move_ready, 0);
    chk("busy_after_verdict", busy, 0);
    path_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, move_ready, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_step"}, step_count, 0);
    chk({tag, "_x"}, cur_x, 0);
    chk({tag, "_y"}, cur_y, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; map_we = 1'b0; map_x = '0; map_y = '0; map_din = 1'b0;
    move = '0; move_valid = 1'b0; path_end = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    load_maze(0);

    // open maze straight to goal, 2 cycles per move
    add_moves(2'd1, 15); add_moves(2'd3, 15);
    run_check(0, 0, cyc);
    chk("t1_latency", cyc, 60);

    // wall at (3,0)
    write_cell(3, 0, 1);
    add_moves(2'd1, 3);
    run_check(0, 0, cyc);

    // out-of-bounds on each edge
    write_cell(3, 0, 0);
    add_moves(2'd0, 1);                      run_check(0, 0, cyc);
    add_moves(2'd2, 1);                      run_check(0, 0, cyc);
    add_moves(2'd1, 16);                     run_check(0, 0, cyc);
    add_moves(2'd3, 15); add_moves(2'd3, 1); run_check(0, 0, cyc);

    // path_end short of goal, then path_end held with every move
    add_moves(2'd1, 4);                      run_check(0, 0, cyc);
    add_moves(2'd3, 15); add_moves(2'd1, 15); run_check(1, 0, cyc);

    // reset mid-CHECK, then identical rerun of the wall case without reloading
    write_cell(3, 0, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; move_valid = 1'b1; move = 2'd1;
    @(negedge clk); move_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_reset_vals("mid_reset");
    add_moves(2'd1, 3);
    run_check(0, 0, cyc);

    // blocked start cell, then a write during WAIT must be ignored
    write_cell(0, 0, 1);
    run_check(0, 0, cyc);
    chk("blocked_start_cycles", cyc, 0);
    write_cell(0, 0, 0);
    write_cell(3, 0, 0);
    add_moves(2'd1, 2);                      run_check(0, 1, cyc);
    add_moves(2'd1, 2);                      run_check(0, 0, cyc);

    // random mazes and biased random paths
    for (int m = 0; m < 4; m++) begin
      load_maze(12);
      for (int t = 0; t < 10; t++) begin
        int len = $urandom_range(1, 60);
        for (int i = 0; i < len; i++) begin
          int r = $urandom_range(0, 9);
          path_q.push_back(r == 0 ? 2'd0 : r == 1 ? 2'd2 : r < 6 ? 2'd1 : 2'd3);
        end
        run_check($urandom_range(0, 1), 0, cyc);
      end
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
